ti_sbox_sched: RTL and testbench

- Sequences the 192-bit, 3-share state through one shared, pipelined threshold-implementation 6-bit S-box datapath, one word per cycle.
- The state is NWORDS 6-bit words; with the default of 32 words this is one full S-box layer.
- Owns share capture and write-back, the datapath pipeline enable, and the start/busy/done handshake.
- Sits between the round controller and the TI S-box datapath (component functions plus inter-stage registers).

---
 rtl/ti_sbox_sched_if.sv | 60 ++++++
 rtl/ti_sbox_sched.sv | 173 +++++++++++++++++
 tb/tb_ti_sbox_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ti_sbox_sched_if.sv
// Signal bundle between the round controller / TI S-box datapath and the layer scheduler.
// The rnd field is present only when TI_SBOX_REFRESH_EN is defined.
interface ti_sbox_sched_if #(
  parameter int NWORDS = 32
);
  // Handshake: start is a request that is taken only in a cycle where busy=0.
  // It is accepted at that clock edge, and busy rises in the next cycle.
  // done pulses for one cycle with busy=0 once every result word is written.
  logic                start;
  logic                busy;
  logic                done;

  logic [6*NWORDS-1:0] state_in_sh1;
  logic [6*NWORDS-1:0] state_in_sh2;
  logic [6*NWORDS-1:0] state_in_sh3;
  logic [6*NWORDS-1:0] state_out_sh1;
  logic [6*NWORDS-1:0] state_out_sh2;
  logic [6*NWORDS-1:0] state_out_sh3;

  logic [5:0]          sb_in_sh1;
  logic [5:0]          sb_in_sh2;
  logic [5:0]          sb_in_sh3;
  logic                sb_en;
  logic [5:0]          sb_out_sh1;
  logic [5:0]          sb_out_sh2;
  logic [5:0]          sb_out_sh3;

`ifdef TI_SBOX_REFRESH_EN
  logic [11:0]         rnd;

  modport master (
    output start, state_in_sh1, state_in_sh2, state_in_sh3,
    output sb_out_sh1, sb_out_sh2, sb_out_sh3, rnd,
    input  busy, done, state_out_sh1, state_out_sh2, state_out_sh3,
    input  sb_in_sh1, sb_in_sh2, sb_in_sh3, sb_en
  );

  modport slave (
    input  start, state_in_sh1, state_in_sh2, state_in_sh3,
    input  sb_out_sh1, sb_out_sh2, sb_out_sh3, rnd,
    output busy, done, state_out_sh1, state_out_sh2, state_out_sh3,
    output sb_in_sh1, sb_in_sh2, sb_in_sh3, sb_en
  );
`else
  modport master (
    output start, state_in_sh1, state_in_sh2, state_in_sh3,
    output sb_out_sh1, sb_out_sh2, sb_out_sh3,
    input  busy, done, state_out_sh1, state_out_sh2, state_out_sh3,
    input  sb_in_sh1, sb_in_sh2, sb_in_sh3, sb_en
  );

  modport slave (
    input  start, state_in_sh1, state_in_sh2, state_in_sh3,
    input  sb_out_sh1, sb_out_sh2, sb_out_sh3,
    output busy, done, state_out_sh1, state_out_sh2, state_out_sh3,
    output sb_in_sh1, sb_in_sh2, sb_in_sh3, sb_en
  );
`endif

endinterface

// File: rtl/ti_sbox_sched.sv
// Streams NWORDS 3-share 6-bit words through one pipelined TI S-box and writes results back.
// Optional fresh-mask refresh of the presented shares: define TI_SBOX_REFRESH_EN.
module ti_sbox_sched #(
  parameter int NWORDS = 32,
  parameter int LAT    = 2
) (
  input  logic           clk,
  input  logic           rst,
  ti_sbox_sched_if.slave bus,
  output logic [1:0]     fsm_state
);

  localparam int            CW   = $clog2(NWORDS + 1);
  localparam int            SW   = 6 * NWORDS;
  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;

  logic [SW-1:0]  in_sh1_q;
  logic [SW-1:0]  in_sh2_q;
  logic [SW-1:0]  in_sh3_q;
  logic [SW-1:0]  out_sh1_q;
  logic [SW-1:0]  out_sh2_q;
  logic [SW-1:0]  out_sh3_q;

  logic [CW-1:0]  in_cnt_q;
  logic [CW-1:0]  out_cnt_q;
  logic [LAT-1:0] vld_q;
  logic           done_q;

  logic           accept;
  logic           feed;
  logic           wb;
  logic           last_wb;
  logic [5:0]     w1;
  logic [5:0]     w2;
  logic [5:0]     w3;

  assign feed    = (state_q == FEED);
  assign wb      = vld_q[LAT-1];
  assign last_wb = wb && (out_cnt_q == LAST);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FEED;
          accept  = 1'b1;
        end
      end
      FEED: begin
        if (in_cnt_q == LAST) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_wb) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and the valid pipe tracking words in flight in the datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      vld_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= (state_q == DRAIN) && last_wb;
      vld_q[0] <= feed;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
      if (accept) begin
        in_cnt_q  <= '0;
        out_cnt_q <= '0;
      end else begin
        if (feed) begin
          in_cnt_q <= in_cnt_q + CW'(1);
        end
        if (wb) begin
          out_cnt_q <= out_cnt_q + CW'(1);
        end
      end
    end
  end

  // Input share capture; each share has its own register and never meets another share
  always_ff @(posedge clk) begin
    if (rst) begin
      in_sh1_q <= '0;
      in_sh2_q <= '0;
      in_sh3_q <= '0;
    end else if (accept) begin
      in_sh1_q <= bus.state_in_sh1;
      in_sh2_q <= bus.state_in_sh2;
      in_sh3_q <= bus.state_in_sh3;
    end
  end

  // Result write-back into word out_cnt, one word per valid pipe output
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sh1_q <= '0;
      out_sh2_q <= '0;
      out_sh3_q <= '0;
    end else if (wb) begin
      for (int k = 0; k < NWORDS; k++) begin
        if (out_cnt_q == CW'(k)) begin
          out_sh1_q[6*k +: 6] <= bus.sb_out_sh1;
          out_sh2_q[6*k +: 6] <= bus.sb_out_sh2;
          out_sh3_q[6*k +: 6] <= bus.sb_out_sh3;
        end
      end
    end
  end

  // Word select for the datapath input
  always_comb begin
    w1 = '0;
    w2 = '0;
    w3 = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (in_cnt_q == CW'(k)) begin
        w1 = in_sh1_q[6*k +: 6];
        w2 = in_sh2_q[6*k +: 6];
        w3 = in_sh3_q[6*k +: 6];
      end
    end
  end

`ifdef TI_SBOX_REFRESH_EN
  logic [5:0] r0;
  logic [5:0] r1;

  assign r0 = bus.rnd[5:0];
  assign r1 = bus.rnd[11:6];

  // r0 and r1 each appear in exactly two shares, so the recombined word is unchanged
  assign bus.sb_in_sh1 = feed ? (w1 ^ r0)      : 6'd0;
  assign bus.sb_in_sh2 = feed ? (w2 ^ r1)      : 6'd0;
  assign bus.sb_in_sh3 = feed ? (w3 ^ r0 ^ r1) : 6'd0;
`else
  assign bus.sb_in_sh1 = feed ? w1 : 6'd0;
  assign bus.sb_in_sh2 = feed ? w2 : 6'd0;
  assign bus.sb_in_sh3 = feed ? w3 : 6'd0;
`endif

  assign bus.sb_en         = (state_q != IDLE);
  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = done_q;
  assign bus.state_out_sh1 = out_sh1_q;
  assign bus.state_out_sh2 = out_sh2_q;
  assign bus.state_out_sh3 = out_sh3_q;
  assign fsm_state         = state_q;

endmodule

// File: tb/tb_ti_sbox_sched.sv
// Bench for ti_sbox_sched with a behavioural 2-stage masked S-box datapath model.
// Build with TI_SBOX_REFRESH_EN defined to exercise the mask-refresh variant.
`timescale 1ns/1ps
module tb_ti_sbox_sched;

  localparam int NWORDS = 32;
  localparam int LAT    = 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] fsm_state;

  always #5 clk = ~clk;

  ti_sbox_sched_if #(.NWORDS(NWORDS)) bus ();

  ti_sbox_sched #(.NWORDS(NWORDS), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference S-box; only the first four entries are fixed, the rest is any bijection-like fill
  function automatic logic [5:0] sbox(input logic [5:0] x);
    case (x)
      6'd0:    sbox = 6'd54;
      6'd1:    sbox = 6'd0;
      6'd2:    sbox = 6'd48;
      6'd3:    sbox = 6'd13;
      default: sbox = 6'((int'(x) * 29 + 7) % 64);
    endcase
  endfunction

  // ---------------- datapath model: LAT=2 register stages, output re-masked ----------------
  logic [5:0] p1_1 = '0, p1_2 = '0, p1_3 = '0;
  logic [5:0] p2_1 = '0, p2_2 = '0, p2_3 = '0;
  logic [5:0] ma, mb;

  always @(posedge clk) begin
    if (bus.sb_en) begin
      ma = 6'($urandom_range(0, 63));
      mb = 6'($urandom_range(0, 63));
      p1_1 <= bus.sb_in_sh1;
      p1_2 <= bus.sb_in_sh2;
      p1_3 <= bus.sb_in_sh3;
      p2_1 <= sbox(p1_1 ^ p1_2 ^ p1_3) ^ ma;
      p2_2 <= mb;
      p2_3 <= ma ^ mb;
    end
  end

  assign bus.sb_out_sh1 = p2_1;
  assign bus.sb_out_sh2 = p2_2;
  assign bus.sb_out_sh3 = p2_3;

  // ---------------- stimulus data sets ----------------
  logic [5:0] va [2][NWORDS];
  logic [5:0] s1 [2][NWORDS];
  logic [5:0] s2 [2][NWORDS];
  logic [5:0] s3 [2][NWORDS];

  logic [5:0] exp_q[$];
  logic [5:0] first_exp [NWORDS];

  typedef struct {
    logic [8*12-1:0] name;
    int pat_a;
    int pat_b;
    int st0;
    int st1;
    int st2;
    int rst_cyc;
    int acc0;
    int acc1;
    int dn0;
    int dn1;
    int hold_cyc;
    int zero_cyc;
    int fixed_rnd;
    int ncyc;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Masked split where no share equals the plain value (all-zero pattern stays unmasked)
  task automatic make_set(input int set, input int pat);
    logic [5:0] v, a, b;
    for (int k = 0; k < NWORDS; k++) begin
      case (pat)
        1:       v = 6'(k % 64);
        2:       v = 6'((k * 7 + 3) % 64);
        3:       v = 6'((k * 13 + 40) % 64);
        default: v = 6'd0;
      endcase
      if (pat == 0) begin
        a = 6'd0;
        b = 6'd0;
      end else begin
        do begin
          a = 6'($urandom_range(0, 63));
          b = 6'($urandom_range(0, 63));
        end while ((a ^ b) == 6'd0 || a == v || b == v);
      end
      va[set][k] = v;
      s2[set][k] = a;
      s3[set][k] = b;
      s1[set][k] = v ^ a ^ b;
    end
  endtask

  task automatic drive_set(input int set);
    for (int k = 0; k < NWORDS; k++) begin
      bus.state_in_sh1[6*k +: 6] = s1[set][k];
      bus.state_in_sh2[6*k +: 6] = s2[set][k];
      bus.state_in_sh3[6*k +: 6] = s3[set][k];
    end
  endtask

  task automatic drive_rnd(input int fixed);
`ifdef TI_SBOX_REFRESH_EN
    bus.rnd = (fixed != 0) ? 12'hAAA : 12'($urandom_range(0, 4095));
`else
    if (fixed != 0) begin
      bus.start = bus.start;
    end
`endif
  endtask

  function automatic logic [5:0] out_word(input int k);
    return bus.state_out_sh1[6*k +: 6] ^ bus.state_out_sh2[6*k +: 6] ^ bus.state_out_sh3[6*k +: 6];
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    drive_rnd(0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset sb_en", 32'(bus.sb_en), 32'd0);
    check("reset sb_in", 32'({bus.sb_in_sh1, bus.sb_in_sh2, bus.sb_in_sh3}), 32'd0);
    check("reset state_out", 32'(|{bus.state_out_sh1, bus.state_out_sh2, bus.state_out_sh3}), 32'd0);
    check("reset fsm", 32'(fsm_state), 32'd0);
    rst = 1'b0;
  endtask

  // ---------------- table-driven sequence runner ----------------
  task automatic run_vec(input vec_t v);
    int         acc [2];
    int         dn [2];
    int         end_c, set_f, word_f;
    logic       eb;
    logic [5:0] e1, e2, e3;
    logic [5:0] got;
    acc[0] = v.acc0;
    acc[1] = v.acc1;
    dn[0]  = v.dn0;
    dn[1]  = v.dn1;
    make_set(0, v.pat_a);
    make_set(1, v.pat_b);
    drive_set(0);
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      if (acc[i] >= 0 && dn[i] >= 0) begin
        for (int k = 0; k < NWORDS; k++) begin
          exp_q.push_back(sbox(va[(acc[i] == 0) ? 0 : 1][k]));
        end
      end
    end
    for (int k = 0; k < NWORDS; k++) begin
      first_exp[k] = sbox(va[0][k]);
    end
    do_reset();
    for (int c = 0; c < v.ncyc; c++) begin
      bus.start = (c == v.st0 || c == v.st1 || c == v.st2);
      rst       = (c == v.rst_cyc);
      if (c == 1) begin
        drive_set(1);
      end
      drive_rnd(v.fixed_rnd);
      @(negedge clk);
      eb     = 1'b0;
      set_f  = -1;
      word_f = 0;
      for (int i = 0; i < 2; i++) begin
        if (acc[i] >= 0) begin
          end_c = (dn[i] >= 0) ? dn[i] - 1 : v.rst_cyc;
          if (c >= acc[i] + 1 && c <= end_c) begin
            eb = 1'b1;
          end
          if (c >= acc[i] + 1 && c <= acc[i] + NWORDS && c <= end_c) begin
            set_f  = (acc[i] == 0) ? 0 : 1;
            word_f = c - acc[i] - 1;
          end
        end
      end
      check("busy", 32'(bus.busy), 32'(eb));
      check("sb_en", 32'(bus.sb_en), 32'(eb));
      check("done", 32'(bus.done), 32'(c == v.dn0 || c == v.dn1));
      check("fsm", 32'(fsm_state), (set_f >= 0) ? 32'd1 : (eb ? 32'd2 : 32'd0));
      e1 = '0;
      e2 = '0;
      e3 = '0;
      if (set_f >= 0) begin
        e1 = s1[set_f][word_f];
        e2 = s2[set_f][word_f];
        e3 = s3[set_f][word_f];
`ifdef TI_SBOX_REFRESH_EN
        e1 = e1 ^ bus.rnd[5:0];
        e2 = e2 ^ bus.rnd[11:6];
        e3 = e3 ^ bus.rnd[5:0] ^ bus.rnd[11:6];
`endif
      end
      check("sb_in", 32'({bus.sb_in_sh1, bus.sb_in_sh2, bus.sb_in_sh3}), 32'({e1, e2, e3}));
      if (c == v.dn0 || c == v.dn1) begin
        for (int k = 0; k < NWORDS; k++) begin
          got = out_word(k);
          check("result word", 32'(got), 32'(exp_q.pop_front()));
        end
      end
      if (c == v.hold_cyc) begin
        for (int k = 0; k < NWORDS; k++) begin
          check("held result", 32'(out_word(k)), 32'(first_exp[k]));
        end
      end
      if (c == v.zero_cyc) begin
        check("state_out after rst", 32'(|{bus.state_out_sh1, bus.state_out_sh2, bus.state_out_sh3}), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    rst       = 1'b0;
  endtask

  // ---------------- main ----------------
  initial begin
    int cyc;
    int nd;
    int d1;
    int d2;
    logic found;

    bus.start        = 1'b0;
    bus.state_in_sh1 = '0;
    bus.state_in_sh2 = '0;
    bus.state_in_sh3 = '0;
    drive_rnd(0);

    vecs[0] = '{name:"zeros", pat_a:0, pat_b:0, st0:0, st1:-1, st2:-1, rst_cyc:-1,
                acc0:0, acc1:-1, dn0:35, dn1:-1, hold_cyc:-1, zero_cyc:-1, fixed_rnd:0, ncyc:38};
    vecs[1] = '{name:"ramp", pat_a:1, pat_b:1, st0:0, st1:-1, st2:-1, rst_cyc:-1,
                acc0:0, acc1:-1, dn0:35, dn1:-1, hold_cyc:-1, zero_cyc:-1, fixed_rnd:0, ncyc:38};
    vecs[2] = '{name:"extra_start", pat_a:2, pat_b:3, st0:0, st1:5, st2:20, rst_cyc:-1,
                acc0:0, acc1:-1, dn0:35, dn1:-1, hold_cyc:-1, zero_cyc:-1, fixed_rnd:0, ncyc:40};
    vecs[3] = '{name:"mid_reset", pat_a:2, pat_b:1, st0:0, st1:17, st2:-1, rst_cyc:15,
                acc0:0, acc1:17, dn0:-1, dn1:52, hold_cyc:-1, zero_cyc:16, fixed_rnd:0, ncyc:55};
    vecs[4] = '{name:"back2back", pat_a:1, pat_b:2, st0:0, st1:35, st2:-1, rst_cyc:-1,
                acc0:0, acc1:35, dn0:35, dn1:70, hold_cyc:36, zero_cyc:-1, fixed_rnd:0, ncyc:73};
    vecs[5] = '{name:"rnd_aaa", pat_a:0, pat_b:0, st0:0, st1:-1, st2:-1, rst_cyc:-1,
                acc0:0, acc1:-1, dn0:35, dn1:-1, hold_cyc:-1, zero_cyc:-1, fixed_rnd:1, ncyc:38};

    for (int i = 0; i < 6; i++) begin
      $display("vector %0d: %s", i, vecs[i].name);
      run_vec(vecs[i]);
    end

    // Hand sequence: ramp layer, wait for done with a cycle budget, check fixed S values
    make_set(0, 1);
    drive_set(0);
    do_reset();
    bus.start = 1'b1;
    drive_rnd(0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc   = 1;
    found = 1'b0;
    while (!found && cyc < 60) begin
      drive_rnd(0);
      @(negedge clk);
      if (bus.done) begin
        found = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    check("ramp done cycle", 32'(cyc), 32'd35);
    check("ramp word0", 32'(out_word(0)), 32'd54);
    check("ramp word1", 32'(out_word(1)), 32'd0);
    check("ramp word2", 32'(out_word(2)), 32'd48);
    check("ramp word3", 32'(out_word(3)), 32'd13);
    @(posedge clk);
    #1;

    // Hand sequence: start held high -> accepted at 0 and again in the done cycle 35
    make_set(0, 2);
    drive_set(0);
    do_reset();
    bus.start = 1'b1;
    nd = 0;
    d1 = -1;
    d2 = -1;
    for (int c = 0; c < 75; c++) begin
      drive_rnd(0);
      @(negedge clk);
      if (bus.done) begin
        nd++;
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    check("held start done count", 32'(nd), 32'd2);
    check("held start done1", 32'(d1), 32'd35);
    check("held start done2", 32'(d2), 32'd70);
    check("held start word5", 32'(out_word(5)), 32'(sbox(6'd38)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
